// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, default ALU latency and controller state encoding for alu_arbiter.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int ALU_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant; ptr picks the winner only when both requesters are valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       idx
);

    assign idx = (&valid) ? ptr : valid[1];
    assign gnt = (|valid) ? (idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one pipelined 4-bit alu between two requesters with round-robin
// grant, fixed-latency result capture and a back-pressured tagged response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_y,
    output logic       rsp_carry,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_y,
    input  logic       alu_carry
);

    localparam int CW = $clog2(ALU_LAT + 2);

    state_t        state, state_nx;
    logic          ptr, owner, idx, acc, done;
    logic [1:0]    gnt;
    logic [CW-1:0] cnt;

    rr_arb2 u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (idx)
    );

    assign req_ready = (state == IDLE) ? gnt : 2'b00;
    assign acc       = |(req_valid & req_ready);
    assign done      = (state == WAIT) && (cnt == '0);

    always_comb begin
        state_nx = state;
        state_nx = acc ? WAIT
                 : done ? RESP
                 : (state == RESP && rsp_ready) ? IDLE
                 : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The alu pipeline is not reset, so alu_y is only sampled on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            alu_op    <= 2'b00;
            alu_a     <= 4'h0;
            alu_b     <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= 4'h0;
            rsp_carry <= 1'b0;
        end else begin
            if (acc) begin
                alu_op <= idx ? req_op[3:2] : req_op[1:0];
                alu_a  <= idx ? req_a[7:4]  : req_a[3:0];
                alu_b  <= idx ? req_b[7:4]  : req_b[3:0];
                owner  <= idx;
                cnt    <= CW'(ALU_LAT);
                ptr    <= ~idx;
            end
            if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (done) begin
                rsp_y     <= alu_y;
                rsp_carry <= alu_carry;
                rsp_id    <= owner;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a two-stage alu model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, alu_carry;
    logic [3:0] rsp_y, alu_a, alu_b, alu_y;
    logic [1:0] alu_op;
    logic [4:0] s1, s2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_carry (rsp_carry),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_carry (alu_carry)
    );

    function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always @(posedge clk) begin
        s1 <= alu_f(alu_op, alu_a, alu_b);
        s2 <= s1;
    end
    assign alu_y     = s2[3:0];
    assign alu_carry = s2[4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[2*id +: 2] = op;
        req_a[4*id +: 4]  = a;
        req_b[4*id +: 4]  = b;
    endtask

    task automatic wait_rsp(input string tag, input logic id, input logic [3:0] y, input logic c);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {7'd0, rsp_valid}, 8'd1);
        chk({tag, "_id"}, {7'd0, rsp_id}, {7'd0, id});
        chk({tag, "_y"}, {4'd0, rsp_y}, {4'd0, y});
        chk({tag, "_c"}, {7'd0, rsp_carry}, {7'd0, c});
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic serve(input string tag, input int id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] y, input logic c);
        int n = 0;
        @(negedge clk);
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        #1;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, {6'd0, req_ready}, (id == 1) ? 8'd2 : 8'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        chk({tag, "_alu_a"}, {4'd0, alu_a}, {4'd0, a});
        chk({tag, "_alu_op"}, {6'd0, alu_op}, {6'd0, op});
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 8'(n), 8'd3);
        wait_rsp(tag, id[0], y, c);
    endtask

    initial begin
        int last, pulses;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        #2;
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_rsp_id", {7'd0, rsp_id}, 8'd0);
        chk("rst_rsp_y", {4'd0, rsp_y}, 8'd0);
        chk("rst_rsp_c", {7'd0, rsp_carry}, 8'd0);
        chk("rst_alu_op", {6'd0, alu_op}, 8'd0);
        chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
        chk("rst_alu_b", {4'd0, alu_b}, 8'd0);
        chk("rst_ready", {6'd0, req_ready}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        serve("add0", 0, 2'b00, 4'h9, 4'h8, 4'h1, 1'b1);
        serve("sub1", 1, 2'b01, 4'h3, 4'h5, 4'hE, 1'b1);
        serve("and1", 1, 2'b10, 4'hC, 4'hA, 4'h8, 1'b0);
        serve("or1", 1, 2'b11, 4'hC, 4'hA, 4'hE, 1'b0);

        // back-pressure: response held, pointer now favours requester 1
        rsp_ready = 1'b0;
        serve("bp0", 0, 2'b00, 4'h7, 4'h7, 4'hE, 1'b0);
        set_req(0, 2'b00, 4'h1, 4'h1);
        set_req(1, 2'b11, 4'h3, 4'h4);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", {6'd0, req_ready}, 8'd0);
            chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
            chk("bp_y", {4'd0, rsp_y}, 8'hE);
            chk("bp_id", {7'd0, rsp_id}, 8'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {7'd0, rsp_valid}, 8'd0);
        chk("bp_ptr_grant", {6'd0, req_ready}, 8'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_rsp("bp_r1", 1'b1, 4'h7, 1'b0);
        chk("bp_next_grant", {6'd0, req_ready}, 8'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp("bp_r0", 1'b0, 4'h2, 1'b0);

        // reset while an op is in flight
        @(negedge clk);
        set_req(0, 2'b00, 4'h5, 4'h5);
        req_valid = 2'b01;
        #1;
        chk("mr_ready", {6'd0, req_ready}, 8'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("mr_alu_a", {4'd0, alu_a}, 8'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_alu_a0", {4'd0, alu_a}, 8'd0);
        chk("mr_alu_b0", {4'd0, alu_b}, 8'd0);
        chk("mr_rsp_valid0", {7'd0, rsp_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mr_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end
        set_req(0, 2'b00, 4'h2, 4'h3);
        set_req(1, 2'b11, 4'h1, 4'h2);
        req_valid = 2'b11;
        #1;
        chk("mr_ptr0", {6'd0, req_ready}, 8'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp("mr_r0", 1'b0, 4'h5, 1'b0);
        chk("mr_then1", {6'd0, req_ready}, 8'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_rsp("mr_r1", 1'b1, 4'h3, 1'b0);

        // both continuously valid: alternate 0,1,0,1
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 2'b01, 4'h8, 4'h3);
        set_req(1, 2'b10, 4'hF, 4'h6);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++)
            wait_rsp("alt", k[0], k[0] ? 4'h6 : 4'h5, 1'b0);
        req_valid = 2'b00;

        // requester 0 alone: one accept every ALU_LAT+3 cycles
        @(negedge clk);
        set_req(0, 2'b00, 4'hF, 4'h1);
        req_valid = 2'b01;
        last = -1;
        pulses = 0;
        for (int c = 0; c < 22; c++) begin
            #1;
            if (req_ready[0]) begin
                pulses++;
                if (last >= 0) chk("tp_gap", 8'(c - last), 8'd5);
                last = c;
            end
            if (req_ready[1]) chk("tp_no_r1", {6'd0, req_ready}, 8'd1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("tp_pulses", 8'(pulses), 8'd5);
        wait_rsp("tp_r0", 1'b0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
